// File: rtl/cordic_sched_pkg.sv
// Shared types for the cordic scheduler: channel IDs, request masks and the
// round-robin scan used to pick which channel feeds the core next.
package cordic_sched_pkg;
  localparam int NREQ_MAX = 8;
  localparam int CH_ID_W  = $clog2(NREQ_MAX);

  typedef logic [CH_ID_W-1:0]  ch_id_t;
  typedef logic [NREQ_MAX-1:0] ch_mask_t;

  typedef struct packed {
    logic   valid;
    ch_id_t id;
  } grant_t;

  // First requesting channel at or above ptr, wrapping from nreq-1 back to 0.
  function automatic grant_t rr_scan(input ch_mask_t req, input ch_id_t ptr, input int nreq);
    grant_t g;
    int     idx;
    g = '0;
    for (int k = 0; k < NREQ_MAX; k++) begin
      idx = int'(ptr) + k;
      if (idx >= nreq) idx = idx - nreq;
      if (k < nreq && !g.valid && req[idx[CH_ID_W-1:0]]) begin
        g.valid = 1'b1;
        g.id    = idx[CH_ID_W-1:0];
      end
    end
    return g;
  endfunction

  function automatic ch_id_t rr_next(input ch_id_t id, input int nreq);
    return (int'(id) == nreq - 1) ? '0 : id + 1'b1;
  endfunction
endpackage

// File: rtl/cordic_sched_if.sv
// Channel-side and core-side FIFO handshakes of the cordic scheduler.
// master = scheduler, slave = requester channels plus the shared core.
interface cordic_sched_if #(parameter int NREQ = 2);
  logic [NREQ-1:0]    ch_in_rd_en;
  logic [NREQ-1:0]    ch_in_empty;
  logic [NREQ*32-1:0] ch_in_dout;
  logic [NREQ-1:0]    ch_sin_wr_en;
  logic [NREQ-1:0]    ch_sin_full;
  logic [NREQ-1:0]    ch_cos_wr_en;
  logic [NREQ-1:0]    ch_cos_full;
  logic [15:0]        ch_sin_din;
  logic [15:0]        ch_cos_din;
  logic               core_in_rd_en;
  logic               core_in_empty;
  logic [31:0]        core_in_dout;
  logic               core_sin_wr_en;
  logic [15:0]        core_sin_din;
  logic               core_sin_full;
  logic               core_cos_wr_en;
  logic [15:0]        core_cos_din;
  logic               core_cos_full;

  modport master (
    output ch_in_rd_en, ch_sin_wr_en, ch_cos_wr_en, ch_sin_din, ch_cos_din,
    output core_in_empty, core_in_dout, core_sin_full, core_cos_full,
    input  ch_in_empty, ch_in_dout, ch_sin_full, ch_cos_full,
    input  core_in_rd_en, core_sin_wr_en, core_sin_din, core_cos_wr_en, core_cos_din
  );

  modport slave (
    input  ch_in_rd_en, ch_sin_wr_en, ch_cos_wr_en, ch_sin_din, ch_cos_din,
    input  core_in_empty, core_in_dout, core_sin_full, core_cos_full,
    output ch_in_empty, ch_in_dout, ch_sin_full, ch_cos_full,
    output core_in_rd_en, core_sin_wr_en, core_sin_din, core_cos_wr_en, core_cos_din
  );
endinterface

// File: rtl/cordic_tag_fifo.sv
// In-order queue of channel IDs for samples currently inside the core.
// Pointers wrap naturally at DEPTH; count is one bit wider to tell full from empty.
module cordic_tag_fifo
  import cordic_sched_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   i_push,
  input  ch_id_t                 i_data,
  input  logic                   i_pop,
  output ch_id_t                 o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);

  ch_id_t        r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/cordic_sched.sv
// Round-robin scheduler sharing one pipelined cordic core between NREQ channels,
// with a tag queue steering each result back to the channel that issued it.
module cordic_sched
  import cordic_sched_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int TAG_DEPTH = 32
) (
  input  logic           clock,
  input  logic           reset_n,
  cordic_sched_if.master bus,
  output logic           err
);
  localparam int CNT_W = $clog2(TAG_DEPTH) + 1;

  ch_id_t           r_rr;
  logic             r_err;
  ch_mask_t         w_req;
  grant_t           w_grant;
  logic             w_push;
  logic             w_pop;
  logic             w_tag_full;
  logic             w_tag_empty;
  ch_id_t           w_head;
  logic [CNT_W-1:0] w_tag_count;
  logic [31:0]      w_dout;
  logic [NREQ-1:0]  w_rd_en;
  logic [NREQ-1:0]  w_sin_wr;
  logic [NREQ-1:0]  w_cos_wr;
  logic             w_head_sin_full;
  logic             w_head_cos_full;

  always_comb begin
    w_req             = '0;
    w_req[NREQ-1:0]   = ~bus.ch_in_empty;
    w_grant           = rr_scan(w_req, r_rr, NREQ);
  end

  // Full is taken from the registered count only: a pop in the same cycle does not free a slot.
  assign bus.core_in_empty = ~w_grant.valid | w_tag_full;
  assign w_push            = bus.core_in_rd_en & ~bus.core_in_empty;
  assign w_pop             = bus.core_sin_wr_en & bus.core_cos_wr_en & ~w_tag_empty;

  always_comb begin
    w_dout          = '0;
    w_rd_en         = '0;
    w_sin_wr        = '0;
    w_cos_wr        = '0;
    w_head_sin_full = 1'b0;
    w_head_cos_full = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant.id == ch_id_t'(i)) begin
        w_dout     = bus.ch_in_dout[32*i +: 32];
        w_rd_en[i] = w_push;
      end
      if (w_head == ch_id_t'(i)) begin
        w_head_sin_full = bus.ch_sin_full[i];
        w_head_cos_full = bus.ch_cos_full[i];
        w_sin_wr[i]     = bus.core_sin_wr_en & ~w_tag_empty;
        w_cos_wr[i]     = bus.core_cos_wr_en & ~w_tag_empty;
      end
    end
  end

  assign bus.core_in_dout  = w_dout;
  assign bus.ch_in_rd_en   = w_rd_en;
  assign bus.ch_sin_wr_en  = w_sin_wr;
  assign bus.ch_cos_wr_en  = w_cos_wr;
  assign bus.ch_sin_din    = bus.core_sin_din;
  assign bus.ch_cos_din    = bus.core_cos_din;
  assign bus.core_sin_full = w_head_sin_full | w_tag_empty;
  assign bus.core_cos_full = w_head_cos_full | w_tag_empty;

  cordic_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tags (
    .clock   (clock),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_data  (w_grant.id),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_tag_full),
    .o_empty (w_tag_empty),
    .o_count (w_tag_count)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_rr  <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_push) r_rr <= rr_next(w_grant.id, NREQ);
      if ((bus.core_sin_wr_en != bus.core_cos_wr_en) ||
          ((bus.core_sin_wr_en | bus.core_cos_wr_en) && w_tag_empty) ||
          (bus.core_in_rd_en && (w_tag_count == CNT_W'(TAG_DEPTH))))
        r_err <= 1'b1;
    end
  end

  assign err = r_err;
endmodule
